// File: rtl/udp_rx_demux.sv
// Steers MAC RX frames to the ARP/ICMP sink (port 1) or the UDP sink (port 2) by parsing
// the Ethernet/IPv4/UDP header in flight while the words wait in an 11-stage delay line.
module udp_rx_demux #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0A02,
    parameter logic [15:0] UDP_PORT = 16'd5000,
    parameter bit          CHECK_IP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_wren,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [1:0]  rx_mod,
    input  logic [31:0] rx_data,
    output logic        rx_wren1,
    output logic        rx_sop1,
    output logic        rx_eop1,
    output logic [1:0]  rx_mod1,
    output logic [31:0] rx_data1,
    output logic        rx_wren2,
    output logic        rx_sop2,
    output logic        rx_eop2,
    output logic [1:0]  rx_mod2,
    output logic [31:0] rx_data2,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);

    typedef struct packed {
        logic        wren;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic [31:0] data;
    } word_t;

    typedef enum logic [1:0] {ROUTE_NONE, ROUTE_1, ROUTE_2, ROUTE_DROP} route_t;
    typedef enum logic [1:0] {IDLE, FWD1, FWD2, DISCARD} tail_state_t;

    localparam int DEPTH = 11;

    word_t       stage [DEPTH];
    word_t       in_word;
    word_t       tail;
    logic        in_hdr;
    logic [3:0]  hdr_cnt;
    logic [15:0] ether_type;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [15:0] dst_ip_hi;
    logic [15:0] dst_ip_lo;
    logic        ip_ok;
    route_t      route;
    route_t      w9_route;
    route_t      tail_route;
    tail_state_t state;
    logic        hdr_gap;
    logic        trunc;

    // Idle cycles enter the line as all-zero words so gaps reach the sinks clean.
    assign in_word = rx_wren ? {1'b1, rx_sop, rx_eop, rx_mod, rx_data} : '0;
    assign tail    = stage[DEPTH-1];
    assign hdr_gap = in_hdr && !rx_wren;
    assign trunc   = tail.sop && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in_word;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        ip_ok    = !CHECK_IP || ({dst_ip_hi, dst_ip_lo} == LOCAL_IP);
        w9_route = ROUTE_DROP;
        if (ether_type == 16'h0806) begin
            w9_route = ROUTE_1;
        end else if (ether_type == 16'h0800 && ver_ihl == 8'h45 && ip_ok) begin
            if (proto == 8'd1)
                w9_route = ROUTE_1;
            else if (proto == 8'd17 && rx_data[31:16] == UDP_PORT)
                w9_route = ROUTE_2;
        end
    end

    // Header parser: hdr_cnt is the index of the word now on rx_data; it parks at 10 once w9 is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_hdr     <= 1'b0;
            hdr_cnt    <= 4'd0;
            route      <= ROUTE_NONE;
            ether_type <= 16'd0;
            ver_ihl    <= 8'd0;
            proto      <= 8'd0;
            dst_ip_hi  <= 16'd0;
            dst_ip_lo  <= 16'd0;
        end else if (rx_wren && rx_sop) begin
            hdr_cnt <= 4'd1;
            in_hdr  <= !rx_eop;
            route   <= rx_eop ? ROUTE_DROP : ROUTE_NONE;
        end else if (hdr_gap) begin
            in_hdr <= 1'b0;
            route  <= ROUTE_DROP;
        end else if (in_hdr) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            case (hdr_cnt)
                4'd3: begin
                    ether_type <= rx_data[31:16];
                    ver_ihl    <= rx_data[15:8];
                end
                4'd5: proto     <= rx_data[7:0];
                4'd7: dst_ip_hi <= rx_data[15:0];
                4'd8: dst_ip_lo <= rx_data[31:16];
                default: ;
            endcase
            if (hdr_cnt == 4'd9) begin
                in_hdr <= 1'b0;
                route  <= w9_route;
            end else if (rx_eop) begin
                in_hdr <= 1'b0;
                route  <= ROUTE_DROP;
            end
        end
    end

    // Snapshot the verdict as the sop passes stage 9, before a zero-gap successor can restart the parser.
    always_ff @(posedge clk) begin
        if (rst)
            tail_route <= ROUTE_NONE;
        else if (stage[DEPTH-2].sop)
            tail_route <= route;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            drop_cnt <= 16'd0;
            {rx_wren1, rx_sop1, rx_eop1, rx_mod1, rx_data1} <= '0;
            {rx_wren2, rx_sop2, rx_eop2, rx_mod2, rx_data2} <= '0;
        end else begin
            {rx_wren1, rx_sop1, rx_eop1, rx_mod1, rx_data1} <= '0;
            {rx_wren2, rx_sop2, rx_eop2, rx_mod2, rx_data2} <= '0;
            if (tail.sop) begin
                case (tail_route)
                    ROUTE_1: begin
                        state <= tail.eop ? IDLE : FWD1;
                        {rx_wren1, rx_sop1, rx_eop1, rx_mod1, rx_data1} <= tail;
                    end
                    ROUTE_2: begin
                        state <= tail.eop ? IDLE : FWD2;
                        {rx_wren2, rx_sop2, rx_eop2, rx_mod2, rx_data2} <= tail;
                    end
                    default: begin
                        state    <= tail.eop ? IDLE : DISCARD;
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                endcase
            end else begin
                case (state)
                    FWD1: begin
                        {rx_wren1, rx_sop1, rx_eop1, rx_mod1, rx_data1} <= tail;
                        if (tail.eop) state <= IDLE;
                    end
                    FWD2: begin
                        {rx_wren2, rx_sop2, rx_eop2, rx_mod2, rx_data2} <= tail;
                        if (tail.eop) state <= IDLE;
                    end
                    DISCARD: if (tail.eop) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= 16'd0;
        else
            err_cnt <= err_cnt + {15'd0, hdr_gap} + {15'd0, trunc};
    end

endmodule
